preamble_tx: RTL

PREAMBLE_TX -- requirements
Module: preamble_tx

---
 rtl/seq_pkg.sv | 16 +
 rtl/piso_shift.sv | 27 ++
 rtl/preamble_tx.sv | 109 ++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the preamble framer: FSM states and the
// fixed 4-bit preamble pattern sent ahead of every payload word.
package seq_pkg;

    typedef enum logic [1:0] {IDLE, PRE, DATA, GAP} state_t;

    localparam int PRE_W = 4;
    localparam logic [PRE_W-1:0] PREAMBLE = 4'b1010;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-in serial-out payload register, MSB first.
// Priority: clear, then load, then shift.
module piso_shift #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] d,
    output logic         msb
);

    logic [W-1:0] q;

    always_ff @(posedge clk) begin
        if (clear)
            q <= '0;
        else if (load)
            q <= d;
        else if (shift)
            q <= q << 1;
    end

    assign msb = q[W-1];

endmodule

// File: rtl/preamble_tx.sv
// Serial framer: emits preamble 1010 then the captured payload MSB first,
// followed by an optional idle gap. Outputs decode from registered state only.
module preamble_tx
    import seq_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              busy,
    output logic              frame_done
);

    localparam int CW = $clog2(max3(DATA_W, GAP_CYCLES, PRE_W)) + 1;
    localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_W - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          load, shift, msb;

    piso_shift #(.W(DATA_W)) u_piso (
        .clk   (clk),
        .clear (rst),
        .load  (load),
        .shift (shift),
        .d     (in_data),
        .msb   (msb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            frame_done <= (state == DATA) && (cnt == '0);
        end
    end

    // cnt holds the index of the bit currently on the line; every phase
    // leaves at zero so the counter never wraps.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        load      = 1'b0;
        shift     = 1'b0;
        in_ready  = 1'b0;
        busy      = 1'b0;
        bit_out   = 1'b0;
        bit_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load     = 1'b1;
                    state_nx = PRE;
                    cnt_nx   = PRE_LAST;
                end
            end
            PRE: begin
                busy      = 1'b1;
                bit_valid = 1'b1;
                bit_out   = PREAMBLE[cnt[1:0]];
                if (cnt == '0) begin
                    state_nx = DATA;
                    cnt_nx   = DATA_LAST;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            DATA: begin
                busy      = 1'b1;
                bit_valid = 1'b1;
                bit_out   = msb;
                shift     = 1'b1;
                if (cnt == '0) begin
                    state_nx = (GAP_CYCLES > 0) ? GAP : IDLE;
                    cnt_nx   = GAP_LAST;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            GAP: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

endmodule
